// File: rtl/bkm_data_step_scoreboard_pkg.sv
// bkm_data_step_scoreboard_pkg: shared FSM encoding and default counter width
package bkm_data_step_scoreboard_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FAILED = 2'd2
    } sb_state_e;
    localparam int CW_DEFAULT = 32;
endpackage

// File: rtl/bkm_data_step_scoreboard_fifo.sv
// bkm_data_step_scoreboard_fifo: synchronous FIFO holding {exp_X,exp_Y} pairs
module bkm_data_step_scoreboard_fifo #(
    parameter int W2    = 128,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W2-1:0]            din,
    output logic [W2-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [W2-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign cnt     = cnt_q;
    assign dout    = mem_q[rd_q];
    assign pop_ok  = pop & ~empty;
    // a full FIFO still accepts a push when the same cycle frees a slot
    assign push_ok = push & (~full | pop_ok);
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (srst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_ok);
            rd_q  <= rd_q + AW'(pop_ok);
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/bkm_data_step_scoreboard.sv
// bkm_data_step_scoreboard: in-order expected/observed X,Y checker with counters and sticky status
// Define BKM_SB_TOL_EN to accept |exp-obs| <= TOL per coordinate instead of exact equality.
module bkm_data_step_scoreboard
    import bkm_data_step_scoreboard_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    parameter int CW    = CW_DEFAULT,
    parameter int TOL   = 0
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     srst,
    input  logic                     enable,
    input  logic                     exp_valid,
    input  logic [W-1:0]             exp_X,
    input  logic [W-1:0]             exp_Y,
    input  logic                     obs_valid,
    input  logic [W-1:0]             res_X_np1,
    input  logic [W-1:0]             res_Y_np1,
    output logic [CW-1:0]            match_cnt,
    output logic [CW-1:0]            err_cnt,
    output logic                     err_flag,
    output logic                     ovf_flag,
    output logic                     udf_flag,
    output logic [4*W-1:0]           first_err,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     busy
);
    logic            push, pop, full, empty, cmp_ok, cmp_pass, cmp_fail;
    logic [2*W-1:0]  fifo_dout;
    sb_state_e       state_q, state_d;
    logic            cmp_vld_q, cmp_vld_d, ovf_q, ovf_d, udf_q, udf_d;
    logic [4*W-1:0]  cmp_q, cmp_d, first_err_q, first_err_d;
    logic [CW-1:0]   match_cnt_q, match_cnt_d, err_cnt_q, err_cnt_d;

    assign push = enable & exp_valid;
    assign pop  = enable & obs_valid & ~empty;

    bkm_data_step_scoreboard_fifo #(.W2(2*W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .srst  (srst),
        .push  (push),
        .pop   (pop),
        .din   ({exp_X, exp_Y}),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .cnt   (fifo_cnt)
    );

`ifdef BKM_SB_TOL_EN
    function automatic logic near(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] d;
        logic [W:0]        m;
        d = $signed({a[W-1], a}) - $signed({b[W-1], b});
        m = d[W] ? -d : d;
        return m <= (W+1)'(TOL);
    endfunction
    assign cmp_ok = near(cmp_q[4*W-1:3*W], cmp_q[2*W-1:W]) & near(cmp_q[3*W-1:2*W], cmp_q[W-1:0]);
`else
    logic unused_tol;
    assign unused_tol = ^TOL;
    assign cmp_ok = (cmp_q[4*W-1:3*W] == cmp_q[2*W-1:W]) & (cmp_q[3*W-1:2*W] == cmp_q[W-1:0]);
`endif

    // the compare captured on the previous pop resolves only while enabled
    assign cmp_pass = enable & cmp_vld_q & cmp_ok;
    assign cmp_fail = enable & cmp_vld_q & ~cmp_ok;

    always_comb begin
        cmp_vld_d   = enable ? pop : cmp_vld_q;
        cmp_d       = pop ? {fifo_dout, res_X_np1, res_Y_np1} : cmp_q;
        match_cnt_d = (cmp_pass & ~&match_cnt_q) ? match_cnt_q + 1'b1 : match_cnt_q;
        err_cnt_d   = (cmp_fail & ~&err_cnt_q) ? err_cnt_q + 1'b1 : err_cnt_q;
        ovf_d       = ovf_q | (push & full & ~pop);
        udf_d       = udf_q | (enable & obs_valid & empty);
        first_err_d = (cmp_fail & state_q != FAILED) ? cmp_q : first_err_q;
        state_d     = cmp_fail                                     ? FAILED :
                      (enable & state_q == IDLE & push)            ? ACTIVE :
                      (enable & state_q == ACTIVE & empty & ~push) ? IDLE   : state_q;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= IDLE;
            cmp_vld_q   <= 1'b0;
            cmp_q       <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            first_err_q <= '0;
        end else if (srst) begin
            state_q     <= IDLE;
            cmp_vld_q   <= 1'b0;
            cmp_q       <= '0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_q       <= cmp_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            first_err_q <= first_err_d;
        end
    end

    assign match_cnt = match_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_flag  = state_q == FAILED;
    assign ovf_flag  = ovf_q;
    assign udf_flag  = udf_q;
    assign first_err = first_err_q;
    assign busy      = ~empty;
endmodule

// File: tb/tb_bkm_data_step_scoreboard.sv
// tb_bkm_data_step_scoreboard: directed stimulus, queue-based reference model and literal checks
module tb_bkm_data_step_scoreboard;
    localparam int W = 16, DEPTH = 8, CW = 4, TOL = 1, FW = $clog2(DEPTH) + 1;
`ifdef BKM_SB_TOL_EN
    localparam bit TOL_EN = 1'b1;
`else
    localparam bit TOL_EN = 1'b0;
`endif
    localparam logic [W-1:0] BAD_X = TOL_EN ? 16'h7 : 16'h6;

    logic clk = 1'b0;
    logic arst, srst, enable, exp_valid, obs_valid;
    logic [W-1:0] exp_X, exp_Y, res_X_np1, res_Y_np1;
    logic [CW-1:0] match_cnt, err_cnt;
    logic err_flag, ovf_flag, udf_flag, busy;
    logic [4*W-1:0] first_err;
    logic [FW-1:0] fifo_cnt;
    int errors = 0, checks = 0;

    bkm_data_step_scoreboard #(.W(W), .DEPTH(DEPTH), .CW(CW), .TOL(TOL)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .exp_valid(exp_valid), .exp_X(exp_X), .exp_Y(exp_Y),
        .obs_valid(obs_valid), .res_X_np1(res_X_np1), .res_Y_np1(res_Y_np1),
        .match_cnt(match_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .ovf_flag(ovf_flag), .udf_flag(udf_flag), .first_err(first_err),
        .fifo_cnt(fifo_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference model: queue of expected pairs plus one pending compare
    logic [2*W-1:0] mq [$];
    logic [CW-1:0]  m_match = '0, m_err = '0;
    bit             m_errf = 0, m_ovf = 0, m_udf = 0, m_pv = 0;
    logic [4*W-1:0] m_pend = '0, m_first = '0;

    function automatic bit agree(input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return TOL_EN ? (d <= TOL && d >= -TOL) : (a == b);
    endfunction

    always @(posedge clk or negedge arst) begin
        int n;
        bit p;
        if (!arst || srst) begin
            mq.delete();
            m_match = '0; m_err = '0; m_errf = 0; m_ovf = 0; m_udf = 0; m_pv = 0;
            m_pend = '0; m_first = '0;
        end else if (enable) begin
            if (m_pv) begin
                if (agree(m_pend[63:48], m_pend[31:16]) && agree(m_pend[47:32], m_pend[15:0])) begin
                    if (m_match != {CW{1'b1}}) m_match = m_match + 1'b1;
                end else begin
                    if (m_err != {CW{1'b1}}) m_err = m_err + 1'b1;
                    if (!m_errf) begin m_errf = 1; m_first = m_pend; end
                end
            end
            n = mq.size();
            p = obs_valid && n > 0;
            m_pv = p;
            if (obs_valid && n == 0) m_udf = 1;
            if (p) m_pend = {mq.pop_front(), res_X_np1, res_Y_np1};
            if (exp_valid) begin
                if (n == DEPTH && !p) m_ovf = 1;
                else mq.push_back({exp_X, exp_Y});
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic ev, input logic [W-1:0] ex, input logic [W-1:0] ey,
                        input logic ov, input logic [W-1:0] ox, input logic [W-1:0] oy);
        enable = en; exp_valid = ev; exp_X = ex; exp_Y = ey;
        obs_valid = ov; res_X_np1 = ox; res_Y_np1 = oy;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        arst = 0; srst = 0; enable = 0; exp_valid = 0; obs_valid = 0;
        exp_X = '0; exp_Y = '0; res_X_np1 = '0; res_Y_np1 = '0;
        fork
            forever begin
                @(negedge clk);
                chk("mdl_match_cnt", 64'(match_cnt), 64'(m_match));
                chk("mdl_err_cnt", 64'(err_cnt), 64'(m_err));
                chk("mdl_err_flag", 64'(err_flag), 64'(m_errf));
                chk("mdl_ovf_flag", 64'(ovf_flag), 64'(m_ovf));
                chk("mdl_udf_flag", 64'(udf_flag), 64'(m_udf));
                chk("mdl_first_err", first_err, m_first);
                chk("mdl_fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
                chk("mdl_busy", 64'(busy), 64'(mq.size() != 0));
            end
        join_none
        #12;
        chk("rst_match", 64'(match_cnt), 0);
        chk("rst_fifo_cnt", 64'(fifo_cnt), 0);
        chk("rst_first_err", first_err, 0);
        arst = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) step(1, 1, 16'(2*i+1), 16'(2*i+2), 0, '0, '0);
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 1, 16'(2*i+1), 16'(2*i+2));
        idle(2);
        chk("t1_match", 64'(match_cnt), 3);
        chk("t1_err", 64'(err_cnt), 0);
        chk("t1_busy", 64'(busy), 0);

        step(1, 1, 16'h5, 16'h7, 0, '0, '0);
        step(1, 0, '0, '0, 1, BAD_X, 16'h7);
        idle(2);
        chk("t2_err", 64'(err_cnt), 1);
        chk("t2_err_flag", 64'(err_flag), 1);
        chk("t2_first_err", first_err, {16'h5, 16'h7, BAD_X, 16'h7});
        step(1, 1, 16'h8, 16'h9, 0, '0, '0);
        step(1, 0, '0, '0, 1, 16'h8, 16'h0);
        idle(2);
        chk("t2_err2", 64'(err_cnt), 2);
        chk("t2_first_err_frozen", first_err, {16'h5, 16'h7, BAD_X, 16'h7});

        step(1, 0, '0, '0, 1, 16'h3, 16'h3);
        idle(1);
        chk("t4_udf", 64'(udf_flag), 1);
        chk("t4_match", 64'(match_cnt), 3);
        chk("t4_err", 64'(err_cnt), 2);

        for (int i = 0; i < 9; i++) step(1, 1, 16'(16'h10 + i), 16'(16'h20 + i), 0, '0, '0);
        chk("t3_ovf", 64'(ovf_flag), 1);
        chk("t3_fifo_full", 64'(fifo_cnt), 8);
        step(1, 1, 16'h30, 16'h40, 1, 16'h10, 16'h20);
        chk("t3_pushpop_full", 64'(fifo_cnt), 8);
        idle(1);
        chk("t3_match", 64'(match_cnt), 4);

        step(1, 0, '0, '0, 1, 16'h11, 16'h21);
        for (int i = 0; i < 5; i++) step(0, 1, 16'hdead, 16'hbeef, 1, '0, '0);
        chk("t5_hold_match", 64'(match_cnt), 4);
        chk("t5_hold_fifo", 64'(fifo_cnt), 7);
        idle(1);
        chk("t5_resume_match", 64'(match_cnt), 5);
        for (int i = 2; i < 8; i++) step(1, 0, '0, '0, 1, 16'(16'h10 + i), 16'(16'h20 + i));
        step(1, 0, '0, '0, 1, 16'h30, 16'h40);
        idle(1);
        chk("t5_drain_match", 64'(match_cnt), 12);
        chk("t5_drain_busy", 64'(busy), 0);

        step(1, 1, 16'h10, 16'h10, 0, '0, '0);
        step(1, 0, '0, '0, 1, 16'h11, 16'h10);
        idle(1);
        chk("t6_off1_match", 64'(match_cnt), TOL_EN ? 13 : 12);
        chk("t6_off1_err", 64'(err_cnt), TOL_EN ? 2 : 3);
        step(1, 1, 16'h10, 16'h10, 0, '0, '0);
        step(1, 0, '0, '0, 1, 16'h12, 16'h10);
        idle(1);
        chk("t6_off2_err", 64'(err_cnt), TOL_EN ? 3 : 4);

        for (int i = 0; i < 5; i++) begin
            step(1, 1, 16'(16'h50 + i), 16'(16'h60 + i), 0, '0, '0);
            step(1, 0, '0, '0, 1, 16'(16'h50 + i), 16'(16'h60 + i));
        end
        idle(1);
        chk("sat_match", 64'(match_cnt), 15);

        step(1, 1, 16'h70, 16'h71, 0, '0, '0);
        step(1, 1, 16'h72, 16'h73, 1, 16'h70, 16'h71);
        exp_valid = 0; obs_valid = 0;
        #2 arst = 0;
        #1;
        chk("arst_match", 64'(match_cnt), 0);
        chk("arst_err", 64'(err_cnt), 0);
        chk("arst_flags", 64'({err_flag, ovf_flag, udf_flag, busy}), 0);
        chk("arst_first_err", first_err, 0);
        chk("arst_fifo_cnt", 64'(fifo_cnt), 0);
        #3 arst = 1;
        @(posedge clk); #1;
        idle(1);
        chk("arst_pending_dropped", 64'(match_cnt), 0);

        step(1, 1, 16'h1, 16'h2, 0, '0, '0);
        step(1, 0, '0, '0, 1, 16'h0, 16'h0);
        chk("pre_srst_udf", 64'(udf_flag), 0);
        step(1, 1, 16'h3, 16'h4, 0, '0, '0);
        srst = 1;
        idle(1);
        srst = 0;
        chk("srst_fifo_cnt", 64'(fifo_cnt), 0);
        chk("srst_err_flag", 64'(err_flag), 0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
